// File: rtl/tl_write_back_pkg.sv
// tl_write_back_pkg: shared MIPS write-back widths and control-field bit positions.
package tl_write_back_pkg;
    localparam int WB_LEN        = 32;
    localparam int WB_NB_CTRL    = 2;
    localparam int WB_NB_ADDR    = 5;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMTOREG = 0;
endpackage

// File: rtl/tl_write_back_mux2_wb.sv
// mux2_wb: write-back data selector, memory word when i_sel is set, ALU result otherwise.
module mux2_wb #(
    parameter int len = 32
) (
    input  logic           i_sel,
    input  logic [len-1:0] i_mem,
    input  logic [len-1:0] i_alu,
    output logic [len-1:0] o_data
);
    assign o_data = i_sel ? i_mem : i_alu;
endmodule

// File: rtl/tl_write_back.sv
// tl_write_back: MIPS write-back stage, one-cycle registered data/address/strobe to the register bank.
module tl_write_back
    import tl_write_back_pkg::*;
#(
    parameter int len                  = WB_LEN,
    parameter int NB_CTRL_WB           = WB_NB_CTRL,
    parameter int NB_ADDRESS_REGISTROS = WB_NB_ADDR
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_valid,
    input  logic [len-1:0]                  i_read_data,
    input  logic [len-1:0]                  i_result_alu,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    output logic [len-1:0]                  o_write_data,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic                            o_RegWrite,
    output logic                            o_valid
);
    logic [len-1:0] w_sel_data;

    mux2_wb #(.len(len)) u_mux (
        .i_sel  (i_ctrl_wb[CTRL_MEMTOREG]),
        .i_mem  (i_read_data),
        .i_alu  (i_result_alu),
        .o_data (w_sel_data)
    );

    // Register 0 is hardwired to zero, so its write strobe is suppressed here.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_write_data <= '0;
            o_write_reg  <= '0;
            o_RegWrite   <= 1'b0;
            o_valid      <= 1'b0;
        end else if (i_enable) begin
            o_write_data <= w_sel_data;
            o_write_reg  <= i_write_reg;
            o_RegWrite   <= i_ctrl_wb[CTRL_REGWRITE] && i_valid && (i_write_reg != '0);
            o_valid      <= i_valid;
        end
    end
endmodule

// File: tb/tb_tl_write_back.sv
// tb_tl_write_back: randomized bench for tl_write_back against a retired-instruction model.
module tb_tl_write_back;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] rd = '0;
    logic [31:0] alu = '0;
    logic [1:0]  ctrl = '0;
    logic [4:0]  wr = '0;
    logic [31:0] o_data;
    logic [4:0]  o_reg;
    logic        o_rw;
    logic        o_vld;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    typedef struct {
        bit        valid;
        bit        is_load;
        bit        writes;
        bit [31:0] mem;
        bit [31:0] alu;
        bit [4:0]  dst;
    } instr_t;

    instr_t retired = '{default: 0};

    tl_write_back dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_valid      (vld),
        .i_read_data  (rd),
        .i_result_alu (alu),
        .i_ctrl_wb    (ctrl),
        .i_write_reg  (wr),
        .o_write_data (o_data),
        .o_write_reg  (o_reg),
        .o_RegWrite   (o_rw),
        .o_valid      (o_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_data(instr_t t);
        return t.is_load ? t.mem : t.alu;
    endfunction

    function automatic logic exp_strobe(instr_t t);
        return t.valid && t.writes && t.dst != 5'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the outputs always describe the last instruction accepted on an enabled edge.
    always @(posedge clk or posedge rst) begin
        if (rst)
            retired = '{default: 0};
        else if (en)
            retired = '{valid: vld, is_load: ctrl[0], writes: ctrl[1], mem: rd, alu: alu, dst: wr};
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_data", o_data, exp_data(retired));
            chk("model_reg", {27'd0, o_reg}, {27'd0, retired.dst});
            chk("model_rw", {31'd0, o_rw}, {31'd0, exp_strobe(retired)});
            chk("model_vld", {31'd0, o_vld}, {31'd0, retired.valid});
        end
    end

    task automatic drive(input logic e, input logic v, input logic [31:0] m, input logic [31:0] a,
                         input logic [1:0] c, input logic [4:0] w);
        @(negedge clk);
        en = e; vld = v; rd = m; alu = a; ctrl = c; wr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] d, input logic [4:0] r,
                       input logic rw, input logic v);
        chk({name, "_data"}, o_data, d);
        chk({name, "_reg"}, {27'd0, o_reg}, {27'd0, r});
        chk({name, "_rw"}, {31'd0, o_rw}, {31'd0, rw});
        chk({name, "_vld"}, {31'd0, o_vld}, {31'd0, v});
    endtask

    initial begin
        #3;
        pin("reset_state", 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        drive(1, 1, 32'h00000002, 32'h00000110, 2'b10, 5'd3);
        pin("alu_write", 32'h00000110, 5'd3, 1'b1, 1'b1);
        drive(1, 1, 32'h00000003, 32'h00000010, 2'b11, 5'd8);
        pin("load_write", 32'h00000003, 5'd8, 1'b1, 1'b1);
        drive(1, 1, 32'h00000044, 32'h00000077, 2'b00, 5'd4);
        pin("store_00", 32'h00000077, 5'd4, 1'b0, 1'b1);
        drive(1, 1, 32'h00000044, 32'h00000077, 2'b01, 5'd4);
        pin("store_01", 32'h00000044, 5'd4, 1'b0, 1'b1);
        drive(1, 1, 32'h00000000, 32'h00000099, 2'b10, 5'd0);
        pin("reg0", 32'h00000099, 5'd0, 1'b0, 1'b1);
        drive(1, 0, 32'h00000000, 32'h00000123, 2'b10, 5'd5);
        pin("bubble", 32'h00000123, 5'd5, 1'b0, 1'b0);
        drive(1, 1, 32'h0, 32'hABCD1234, 2'b10, 5'd7);
        for (int i = 0; i < 3; i++) begin
            drive(0, $urandom_range(0, 1), $urandom, $urandom, 2'($urandom), 5'($urandom));
            pin("stall", 32'hABCD1234, 5'd7, 1'b1, 1'b1);
        end
        drive(1, 1, 32'h0, 32'h0000BEEF, 2'b10, 5'd12);
        #1 rst = 1'b1;
        #1 pin("async_reset", 32'h0, 5'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        drive(1, 1, 32'h00000055, 32'h00000066, 2'b11, 5'd9);
        pin("post_reset", 32'h00000055, 5'd9, 1'b1, 1'b1);
        repeat (400) begin
            @(negedge clk);
            en   = $urandom_range(0, 4) != 0;
            vld  = $urandom_range(0, 3) != 0;
            rd   = $urandom;
            alu  = $urandom;
            ctrl = 2'($urandom);
            wr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            @(posedge clk);
            if ($urandom_range(0, 29) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1 chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tl_write_back.md
TL_WRITE_BACK -- requirements
Module: tl_write_back

Interface
REQ-001 The parameter len SHALL default to 32 and set the data-word width.
REQ-002 The parameter NB_CTRL_WB SHALL default to 2 and set the write-back control-field width.
REQ-003 The parameter NB_ADDRESS_REGISTROS SHALL default to 5 and set the register-address width.
REQ-004 The design SHALL use one clock and an asynchronous, active-high reset; the ports are i_clk and i_reset.
REQ-005 i_clk SHALL be an input, 1 bit wide: the single clock, with all state updating on its rising edge.
REQ-006 i_reset SHALL be an input, 1 bit wide: the asynchronous, active-high reset.
REQ-007 i_enable SHALL be an input, 1 bit wide: stage advance (0 = stall, hold outputs).
REQ-008 i_valid SHALL be an input, 1 bit wide: the inputs carry a real instruction.
REQ-009 i_read_data SHALL be an input, len bits wide: the data-memory read word.
REQ-010 i_result_alu SHALL be an input, len bits wide: the ALU result.
REQ-011 i_ctrl_wb SHALL be an input, NB_CTRL_WB bits wide: bit 1 = RegWrite, bit 0 = MemtoReg.
REQ-012 i_write_reg SHALL be an input, NB_ADDRESS_REGISTROS bits wide: the destination register index.
REQ-013 o_write_data SHALL be an output, len bits wide: the data presented to the register bank.
REQ-014 o_write_reg SHALL be an output, NB_ADDRESS_REGISTROS bits wide: the destination index presented to the register bank.
REQ-015 o_RegWrite SHALL be an output, 1 bit wide: the register-bank write strobe.
REQ-016 o_valid SHALL be an output, 1 bit wide: the outputs hold a retired instruction.

Function
REQ-017 Data selection SHALL be: sel_data = i_ctrl_wb[0] ? i_read_data : i_result_alu, with the full len bits passed unmodified.
REQ-018 On a rising i_clk edge with i_enable=1, the block SHALL register sel_data into o_write_data, i_write_reg into o_write_reg, and i_valid into o_valid.
REQ-019 On that same edge, o_RegWrite SHALL be registered as i_ctrl_wb[1] AND i_valid AND (i_write_reg != 0).
REQ-020 Latency SHALL be exactly one clock from input to outputs; there is no combinational path from any input to any output.
REQ-021 With i_enable=0, all outputs SHALL hold their previous values, regardless of the other inputs.
REQ-022 Writes to register 0 SHALL be suppressed: o_RegWrite=0, while o_write_data and o_write_reg still update.
REQ-023 With i_valid=0 (bubble), o_RegWrite and o_valid SHALL be 0 on the next enabled edge; the data and address outputs SHALL still update (don't-care to consumers).
REQ-024 i_ctrl_wb bits at index 2 or above (when NB_CTRL_WB > 2) SHALL be ignored.
REQ-025 All outputs SHALL be driven at all times; there SHALL be no X propagation from an unselected source.

Reset
REQ-026 Asserting i_reset SHALL immediately force o_write_data=0, o_write_reg=0, o_RegWrite=0 and o_valid=0, independent of i_clk.
REQ-027 Reset SHALL override i_enable.
REQ-028 If i_reset asserts mid-stream, the in-flight instruction SHALL be discarded and SHALL NOT be written.
REQ-029 After i_reset deasserts, the first enabled rising edge SHALL capture new inputs normally.

Structure
REQ-030 The bit positions of i_ctrl_wb (RegWrite index 1, MemtoReg index 0) and the default widths SHALL be localparams in the shared MIPS package, also used by the control unit.
REQ-031 The block SHALL be one module containing the selection mux and the output register.
REQ-032 The mux MAY be a sub-module named mux2_wb, parameterised by len.

Verification
REQ-033 ALU-type write: i_valid=1, i_ctrl_wb=2'b10, i_result_alu=32'h00000110, i_read_data=32'h00000002, i_write_reg=5'd3 -> one clock later o_write_data=32'h00000110, o_write_reg=3, o_RegWrite=1, o_valid=1.
REQ-034 Load write: i_ctrl_wb=2'b11, i_read_data=32'h00000003, i_result_alu=32'h00000010, i_write_reg=5'd8 -> o_write_data=32'h00000003, o_write_reg=8, o_RegWrite=1.
REQ-035 Non-writing instruction (e.g. a store): i_ctrl_wb=2'b00 or 2'b01 -> o_RegWrite=0, o_valid=1.
REQ-036 Write to register 0: i_ctrl_wb=2'b10, i_write_reg=0 -> o_RegWrite=0.
REQ-037 Stall: i_enable=0 for 3 cycles while the inputs change -> outputs remain constant.
REQ-038 Reset: i_reset pulsed between clock edges while o_RegWrite=1 -> all outputs become 0 immediately, before the next i_clk edge.
